// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state and iterative-unit mode encodings for the multi-cycle ALU.
// The opcode values are the R-type funct codes of the execute stage.
package alu_pkg;

  localparam int NB_FUNCT = 6;

  typedef logic [NB_FUNCT-1:0] op_t;

  localparam op_t OP_SLL  = 6'b000000;
  localparam op_t OP_SRL  = 6'b000010;
  localparam op_t OP_SRA  = 6'b000011;
  localparam op_t OP_MULU = 6'b011001;
  localparam op_t OP_DIVU = 6'b011011;
  localparam op_t OP_REMU = 6'b011110;
  localparam op_t OP_ADD  = 6'b100000;
  localparam op_t OP_SUB  = 6'b100010;
  localparam op_t OP_AND  = 6'b100100;
  localparam op_t OP_OR   = 6'b100101;
  localparam op_t OP_XOR  = 6'b100110;
  localparam op_t OP_NOR  = 6'b100111;
  localparam op_t OP_SLT  = 6'b101010;
  localparam op_t OP_SLTU = 6'b101011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

  function automatic logic is_iter_op(input op_t op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle of the multi-cycle ALU.
// slave = ALU side, master = pipeline (requester and result consumer) side.
interface alu_mc_if #(
  parameter int NB_REG = 32,
  parameter int NB_OP  = 6
);

  logic              i_valid;
  logic              o_ready;
  logic [NB_REG-1:0] i_a;
  logic [NB_REG-1:0] i_b;
  logic [NB_OP-1:0]  i_op;
  logic              o_valid;
  logic              i_ready;
  logic [NB_REG-1:0] o_out;
  logic              o_illegal;

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_ready,
    output o_ready, o_valid, o_out, o_illegal
  );

  modport master (
    output i_valid, i_a, i_b, i_op, i_ready,
    input  o_ready, o_valid, o_out, o_illegal
  );

endinterface

// File: rtl/alu_iter.sv
// Shared shift-add multiplier / restoring divider, one bit per cycle; o_done on the NB_REG-th step.
// No backpressure: o_lo/o_hi are valid only in the o_done cycle and must be captured then.
module alu_iter
  import alu_pkg::*;
#(
  parameter int NB_REG = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  iter_mode_t        i_mode,
  input  logic [NB_REG-1:0] i_a,
  input  logic [NB_REG-1:0] i_b,
  output logic              o_done,
  output logic [NB_REG-1:0] o_lo,
  output logic [NB_REG-1:0] o_hi
);

  localparam int NB_CNT = $clog2(NB_REG);

  logic              busy_q, busy_d;
  iter_mode_t        mode_q, mode_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  // acc: product accumulator / partial remainder
  // x:   multiplier (shifts right) / dividend becoming quotient (shifts left)
  // y:   multiplicand (shifts left) / divisor (static)
  logic [NB_REG-1:0] acc_q, acc_d;
  logic [NB_REG-1:0] x_q, x_d;
  logic [NB_REG-1:0] y_q, y_d;
  logic [NB_REG:0]   trial;
  logic [NB_REG:0]   diff;

  always_comb begin
    busy_d = busy_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    trial  = '0;
    diff   = '0;
    o_done = 1'b0;

    if (i_start) begin
      busy_d = 1'b1;
      mode_d = i_mode;
      cnt_d  = NB_CNT'(NB_REG - 1);
      acc_d  = '0;
      x_d    = (i_mode == MODE_MUL) ? i_b : i_a;
      y_d    = (i_mode == MODE_MUL) ? i_a : i_b;
    end else if (busy_q) begin
      if (mode_q == MODE_MUL) begin
        if (x_q[0]) begin
          acc_d = acc_q + y_q;
        end
        x_d = x_q >> 1;
        y_d = y_q << 1;
      end else begin
        // trial < 2*divisor, so bit NB_REG of diff is a clean borrow flag;
        // a zero divisor never borrows, giving all-ones quotient and rem = dividend.
        trial = {acc_q, x_q[NB_REG-1]};
        diff  = trial - {1'b0, y_q};
        if (!diff[NB_REG]) begin
          acc_d = diff[NB_REG-1:0];
          x_d   = {x_q[NB_REG-2:0], 1'b1};
        end else begin
          acc_d = trial[NB_REG-1:0];
          x_d   = {x_q[NB_REG-2:0], 1'b0};
        end
      end

      if (cnt_q == '0) begin
        busy_d = 1'b0;
        o_done = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    o_lo = (mode_q == MODE_MUL) ? acc_d : x_d;
    o_hi = acc_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops 1 cycle accept->o_valid, MULU/DIVU/REMU NB_REG+1 cycles.
// Backpressure: a pending result is held while i_ready=0 and o_ready drops; o_ready also low during ITER.
module alu_mc
  import alu_pkg::*;
#(
  parameter int NB_REG = 32,
  parameter int NB_OP  = 6
) (
  input logic     i_clk,
  input logic     i_rst,
  alu_mc_if.slave bus
);

  localparam int NB_SH = $clog2(NB_REG);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [NB_REG-1:0] out_q, out_d;
  logic              illegal_q, illegal_d;
  logic              rem_q, rem_d;

  logic [NB_OP-1:0]  op_raw;
  op_t               op_fn;
  logic [NB_SH-1:0]  shamt;
  logic [NB_REG-1:0] sc_res;
  logic              sc_ill;
  logic              ready_w;
  logic              accept;
  logic              iter_start;
  iter_mode_t        iter_mode;
  logic              iter_done;
  logic [NB_REG-1:0] iter_lo;
  logic [NB_REG-1:0] iter_hi;

  assign op_raw    = bus.i_op;
  assign op_fn     = op_t'(op_raw);
  assign iter_mode = (op_fn == OP_MULU) ? MODE_MUL : MODE_DIV;

  assign ready_w   = (state_q == ST_IDLE) && (!valid_q || bus.i_ready) && !i_rst;
  assign accept    = bus.i_valid && ready_w;

  assign bus.o_ready   = ready_w;
  assign bus.o_valid   = valid_q;
  assign bus.o_out     = out_q;
  assign bus.o_illegal = illegal_q;

  always_comb begin
    shamt  = bus.i_b[NB_SH-1:0];
    sc_res = '0;
    sc_ill = 1'b0;
    case (op_fn)
      OP_SLL:  sc_res = bus.i_a << shamt;
      OP_SRL:  sc_res = bus.i_a >> shamt;
      OP_SRA:  sc_res = $signed(bus.i_a) >>> shamt;
      OP_ADD:  sc_res = bus.i_a + bus.i_b;
      OP_SUB:  sc_res = bus.i_a - bus.i_b;
      OP_AND:  sc_res = bus.i_a & bus.i_b;
      OP_OR:   sc_res = bus.i_a | bus.i_b;
      OP_XOR:  sc_res = bus.i_a ^ bus.i_b;
      OP_NOR:  sc_res = ~(bus.i_a | bus.i_b);
      OP_SLT:  sc_res = {{(NB_REG-1){1'b0}}, $signed(bus.i_a) < $signed(bus.i_b)};
      OP_SLTU: sc_res = {{(NB_REG-1){1'b0}}, bus.i_a < bus.i_b};
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    out_d      = out_q;
    illegal_d  = illegal_q;
    rem_d      = rem_q;
    iter_start = 1'b0;

    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter_op(op_fn)) begin
            iter_start = 1'b1;
            rem_d      = (op_fn == OP_REMU);
            state_d    = ST_ITER;
          end else begin
            // a same-cycle retire is overridden here, keeping o_valid high
            out_d     = sc_res;
            illegal_d = sc_ill;
            valid_d   = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (iter_done) begin
          out_d     = rem_q ? iter_hi : iter_lo;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      out_q     <= '0;
      illegal_q <= 1'b0;
      rem_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
      rem_q     <= rem_d;
    end
  end

  alu_iter #(
    .NB_REG (NB_REG)
  ) u_iter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (iter_start),
    .i_mode  (iter_mode),
    .i_a     (bus.i_a),
    .i_b     (bus.i_b),
    .o_done  (iter_done),
    .o_lo    (iter_lo),
    .o_hi    (iter_hi)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed spec vectors plus a randomized mix with random consumer stalls,
// all results checked through an expected-result queue.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_mc_if #(.NB_REG(32), .NB_OP(6)) bus ();

  alu_mc #(.NB_REG(32), .NB_OP(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ill;
    logic [31:0] out;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input op_t op);
    exp_t e;
    e.ill = 1'b0;
    e.out = '0;
    case (op)
      OP_SLL:  e.out = a << b[4:0];
      OP_SRL:  e.out = a >> b[4:0];
      OP_SRA:  e.out = $signed(a) >>> b[4:0];
      OP_ADD:  e.out = a + b;
      OP_SUB:  e.out = a - b;
      OP_AND:  e.out = a & b;
      OP_OR:   e.out = a | b;
      OP_XOR:  e.out = a ^ b;
      OP_NOR:  e.out = ~(a | b);
      OP_SLT:  e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.out = (a < b) ? 32'd1 : 32'd0;
      OP_MULU: e.out = a * b;
      OP_DIVU: e.out = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: e.out = (b == 0) ? a : a % b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // result monitor: every retire pops the oldest expected result
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out", bus.o_out, mon_e.out);
        chk("illegal", bus.o_illegal, mon_e.ill);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input op_t op,
                      input logic [31:0] eo, input logic ei);
    bit   ok;
    exp_t e;
    ok          = 1'b0;
    e.out       = eo;
    e.ill       = ei;
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_op    = op;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.i_ready = ($urandom_range(0, 3) != 0);
    end
    bus.i_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic sendm(input logic [31:0] a, input logic [31:0] b, input op_t op);
    exp_t e;
    e = model(a, b, op);
    send(a, b, op, e.out, e.ill);
  endtask

  task automatic drain();
    bit done;
    done        = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.o_valid && bus.o_ready) done = 1'b1;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  op_t op_tab[16] = '{OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                      OP_NOR, OP_SLT, OP_SLTU, OP_MULU, OP_DIVU, OP_REMU, 6'b111111, 6'b000001};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] ra, rb;
    op_t rop;

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_op    = '0;
    bus.i_ready = 1'b1;

    #2;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_out", bus.o_out, 0);
    chk("rst_illegal", bus.o_illegal, 0);
    chk("rst_ready", bus.o_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.o_ready, 1);
    @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    send(32'd5, 32'd7, OP_ADD, 32'h0000_000C, 1'b0);
    send(32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    chk("b2b_valid", bus.o_valid, 1);
    @(posedge clk);
    #1;

    send(32'h8000_0000, 32'd4, OP_SRA, 32'hF800_0000, 1'b0);
    send(32'h8000_0000, 32'd4, OP_SRL, 32'h0800_0000, 1'b0);
    send(32'h0000_0001, 32'd33, OP_SLL, 32'h0000_0002, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, OP_SLT, 32'h0000_0001, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, OP_SLTU, 32'h0000_0000, 1'b0);
    send(32'hF0F0_1234, 32'h0FF0_FF00, OP_AND, 32'h00F0_1200, 1'b0);
    send(32'hF000_0000, 32'h0000_000F, OP_OR, 32'hF000_000F, 1'b0);
    send(32'hFFFF_0000, 32'h0F0F_0F0F, OP_XOR, 32'hF0F0_0F0F, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, OP_NOR, 32'hFFFF_FFFF, 1'b0);

    // multiply latency: ready low 32 cycles, result on the 33rd
    send(32'h0001_0003, 32'h0000_0100, OP_MULU, 32'h0100_0300, 1'b0);
    seen = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.o_ready || bus.o_valid) seen++;
    end
    chk("mul_busy_cycles", seen, 0);
    @(negedge clk);
    chk("mul_latency", bus.o_valid, 1);
    @(posedge clk);
    #1;

    send(32'd100, 32'd7, OP_DIVU, 32'd14, 1'b0);
    send(32'd100, 32'd7, OP_REMU, 32'd2, 1'b0);
    send(32'd9, 32'd0, OP_DIVU, 32'hFFFF_FFFF, 1'b0);
    send(32'd9, 32'd0, OP_REMU, 32'd9, 1'b0);
    drain();

    // backpressure hold, then retire and accept in the same cycle
    bus.i_ready = 1'b0;
    send(32'd1, 32'd2, OP_ADD, 32'd3, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_a     = 32'd10;
    bus.i_b     = 32'd4;
    bus.i_op    = OP_SUB;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out", bus.o_out, 32'd3);
      chk("bp_valid", bus.o_valid, 1);
      chk("bp_ready", bus.o_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    send(32'd10, 32'd4, OP_SUB, 32'd6, 1'b0);
    drain();

    // reset on the 10th ITER cycle of a divide
    send(32'd1000, 32'd3, OP_DIVU, 32'd333, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_out", bus.o_out, 0);
    chk("midrst_ready", bus.o_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    chk("no_result_after_rst", seen, 0);
    @(posedge clk);
    #1;
    send(32'h1234, 32'h5678, 6'b111111, 32'd0, 1'b1);
    @(negedge clk);
    chk("ill_valid", bus.o_valid, 1);
    chk("ill_flag", bus.o_illegal, 1);
    @(posedge clk);
    #1;
    drain();

    // random mix with a randomly stalling consumer
    rnd_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      rop = op_tab[$urandom_range(0, 15)];
      sendm(ra, rb, rop);
    end
    rnd_rdy = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
